// File: rtl/gray_count_decoder_pkg.sv
// rtl/gray_count_decoder_pkg.sv - shared types and Gray helpers for the Gray count decoder
package gray_pkg;

  localparam int MAX_W = 32;

  typedef enum logic {S_INIT, S_TRACK} state_t;

  // Zero-extended Gray words decode correctly: leading zeros leave the XOR prefix untouched.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic popcount1(input logic [MAX_W-1:0] v);
    return (v != '0) && ((v & (v - {{(MAX_W-1){1'b0}}, 1'b1})) == '0);
  endfunction

endpackage

// File: rtl/gray_count_decoder_if.sv
// rtl/gray_count_decoder_if.sv - Gray count bus and decoded status signals
interface gray_count_decoder_if #(
  parameter int W         = 3,
  parameter int ERR_CNT_W = 8
);
  logic [W-1:0]         gray_in;
  logic                 err_clr;
  logic [W-1:0]         bin_out;
  logic                 step_valid;
  logic                 step_dn;
  logic                 wrap_pulse;
  logic                 err_pulse;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output gray_in, err_clr,
    input  bin_out, step_valid, step_dn, wrap_pulse, err_pulse, err_sticky, err_count
  );

  modport slave (
    input  gray_in, err_clr,
    output bin_out, step_valid, step_dn, wrap_pulse, err_pulse, err_sticky, err_count
  );
endinterface

// File: rtl/gray_bus_sync.sv
// rtl/gray_bus_sync.sv - plain flop chain synchroniser for a multi-bit Gray bus
module gray_bus_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_count_decoder.sv
// rtl/gray_count_decoder.sv - synchronise a Gray count, decode to binary, classify each change
module gray_count_decoder
  import gray_pkg::*;
#(
  parameter int MOD_VALUE   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_CNT_W   = 8,
  localparam int W          = $clog2(MOD_VALUE)
) (
  input logic              clk,
  input logic              rstn,
  gray_count_decoder_if.slave bus
);

  localparam logic [W-1:0] TOP = W'(MOD_VALUE - 1);

  logic [W-1:0]     g_s;
  logic [MAX_W-1:0] b_full;
  logic [W-1:0]     g_q;
  logic [W-1:0]     b_q;
  logic             range_q;
  logic [W-1:0]     g_ref;
  logic [W-1:0]     b_ref;
  logic [W-1:0]     bin_r;

  state_t state;
  state_t state_nxt;

  logic changed, single, wrap_up, wrap_dn, legal_up, legal_dn;
  logic [W-1:0] up_val, dn_val;
  logic load_ref, step_nxt, dn_nxt, wrap_nxt, err_nxt;

  logic                 step_r, dn_r, wrap_r, err_r, sticky_r;
  logic [ERR_CNT_W-1:0] count_r;

  gray_bus_sync #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.gray_in),
    .q    (g_s)
  );

  assign b_full = gray2bin(MAX_W'(g_s));

  // Decode stage: one register between synchroniser and classifier keeps the compare path short.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      g_q     <= '0;
      b_q     <= '0;
      range_q <= 1'b1;
    end else begin
      g_q     <= g_s;
      b_q     <= b_full[W-1:0];
      range_q <= (b_full < MAX_W'(MOD_VALUE));
    end
  end

  always_comb begin
    changed  = (g_q != g_ref);
    single   = popcount1(MAX_W'(g_q ^ g_ref));
    up_val   = (b_ref == TOP) ? '0 : b_ref + 1'b1;
    dn_val   = (b_ref == '0) ? TOP : b_ref - 1'b1;
    wrap_up  = (b_ref == TOP) && (b_q == '0);
    wrap_dn  = (b_ref == '0) && (b_q == TOP);
    legal_up = range_q && (b_q == up_val) && (single || wrap_up);
    legal_dn = range_q && (b_q == dn_val) && (single || wrap_dn);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_ref  = 1'b0;
    step_nxt  = 1'b0;
    dn_nxt    = 1'b0;
    wrap_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_INIT: begin
        load_ref  = 1'b1;
        state_nxt = S_TRACK;
      end
      S_TRACK: begin
        if (changed) begin
          // Any change, legal or not, becomes the new reference so tracking resumes from it.
          load_ref = 1'b1;
          if (legal_up) begin
            step_nxt = 1'b1;
            wrap_nxt = wrap_up;
          end else if (legal_dn) begin
            step_nxt = 1'b1;
            dn_nxt   = 1'b1;
            wrap_nxt = wrap_dn;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      g_ref  <= '0;
      b_ref  <= '0;
      bin_r  <= '0;
      step_r <= 1'b0;
      dn_r   <= 1'b0;
      wrap_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (load_ref) begin
        g_ref <= g_q;
        b_ref <= b_q;
        bin_r <= b_q;
      end
      step_r <= step_nxt;
      dn_r   <= dn_nxt;
      wrap_r <= wrap_nxt;
      err_r  <= err_nxt;
    end
  end

  // A clear coinciding with a new error still records that error in the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_r <= 1'b0;
      count_r  <= '0;
    end else if (bus.err_clr) begin
      sticky_r <= 1'b0;
      count_r  <= err_nxt ? {{(ERR_CNT_W-1){1'b0}}, 1'b1} : '0;
    end else if (err_nxt) begin
      sticky_r <= 1'b1;
      if (count_r != '1) begin
        count_r <= count_r + 1'b1;
      end
    end
  end

  assign bus.bin_out    = bin_r;
  assign bus.step_valid = step_r;
  assign bus.step_dn    = dn_r;
  assign bus.wrap_pulse = wrap_r;
  assign bus.err_pulse  = err_r;
  assign bus.err_sticky = sticky_r;
  assign bus.err_count  = count_r;

endmodule

// File: tb/tb_gray_count_decoder.sv
// tb/tb_gray_count_decoder.sv - directed vector bench for gray_count_decoder (MOD 8 and MOD 6)
module tb_gray_count_decoder;

  logic clk;
  logic rstn;

  gray_count_decoder_if #(.W(3), .ERR_CNT_W(8)) if8 ();
  gray_count_decoder_if #(.W(3), .ERR_CNT_W(8)) if6 ();

  gray_count_decoder #(.MOD_VALUE(8), .SYNC_STAGES(2), .ERR_CNT_W(8)) u_dut8 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if8)
  );

  gray_count_decoder #(.MOD_VALUE(6), .SYNC_STAGES(2), .ERR_CNT_W(8)) u_dut6 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (if6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] bin;
    logic       step;
    logic       dn;
    logic       wrap;
    logic       err;
    logic       sticky;
    logic [7:0] cnt;
  } obs_t;

  typedef struct packed {
    logic       sel;
    logic [2:0] gray;
    obs_t       exp;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  function automatic obs_t observe(input logic sel);
    obs_t o;
    if (sel) begin
      o = '{if6.bin_out, if6.step_valid, if6.step_dn, if6.wrap_pulse,
            if6.err_pulse, if6.err_sticky, if6.err_count};
    end else begin
      o = '{if8.bin_out, if8.step_valid, if8.step_dn, if8.wrap_pulse,
            if8.err_pulse, if8.err_sticky, if8.err_count};
    end
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("bin=%0d step=%0b dn=%0b wrap=%0b err=%0b sticky=%0b cnt=%0d",
                     o.bin, o.step, o.dn, o.wrap, o.err, o.sticky, o.cnt);
  endfunction

  task automatic check(input bit ok, input string name, input string act, input string exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic sel, input logic [2:0] gray, input logic [2:0] bin,
                              input logic step, input logic dn, input logic wrap, input logic err,
                              input logic sticky, input logic [7:0] cnt);
    vec_t v;
    v.sel  = sel;
    v.gray = gray;
    v.exp  = '{bin, step, dn, wrap, err, sticky, cnt};
    return v;
  endfunction

  // Drive one Gray value, confirm nothing moves before the latency, then compare the landing cycle.
  task automatic apply(input vec_t v, input int idx);
    obs_t pre, o;
    bit   ok;
    pre = observe(v.sel);
    if (v.sel) if6.gray_in = v.gray;
    else       if8.gray_in = v.gray;
    repeat (3) @(posedge clk);
    #1;
    o = observe(v.sel);
    check(o.bin == pre.bin && !o.step && !o.wrap && !o.err,
          $sformatf("latency_v%0d", idx), fmt(o), $sformatf("bin=%0d, no pulses", pre.bin));
    @(posedge clk);
    #1;
    o  = observe(v.sel);
    ok = (o.bin == v.exp.bin) && (o.step == v.exp.step) && (!v.exp.step || o.dn == v.exp.dn) &&
         (o.wrap == v.exp.wrap) && (o.err == v.exp.err) && (o.sticky == v.exp.sticky) &&
         (o.cnt == v.exp.cnt);
    check(ok, $sformatf("vec_%0d", idx), fmt(o), fmt(v.exp));
  endtask

  initial begin
    obs_t o;
    int   pulses;

    //           sel  gray    bin  stp dn wrp err stk cnt
    vecs.push_back(mk(0, 3'b100, 3'd7, 1, 1, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b101, 3'd6, 1, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b111, 3'd5, 1, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b110, 3'd4, 1, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b010, 3'd3, 1, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b011, 3'd2, 1, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b001, 3'd1, 1, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b000, 3'd0, 1, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b100, 3'd7, 1, 1, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b101, 3'd6, 1, 1, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b100, 3'd7, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b000, 3'd0, 1, 0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 3'b011, 3'd2, 0, 0, 0, 1, 1, 8'd1));
    vecs.push_back(mk(0, 3'b010, 3'd3, 1, 0, 0, 0, 1, 8'd1));
    vecs.push_back(mk(1, 3'b001, 3'd1, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(1, 3'b011, 3'd2, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(1, 3'b010, 3'd3, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(1, 3'b110, 3'd4, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(1, 3'b111, 3'd5, 1, 0, 0, 0, 0, 8'd0));
    vecs.push_back(mk(1, 3'b000, 3'd0, 1, 0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 3'b111, 3'd5, 1, 1, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 3'b000, 3'd0, 1, 0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 3'b101, 3'd6, 0, 0, 0, 1, 1, 8'd1));

    rstn        = 1'b0;
    if8.gray_in = 3'b000;
    if8.err_clr = 1'b0;
    if6.gray_in = 3'b000;
    if6.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = observe(1'b0);
    check(o == '0, "reset_mod8", fmt(o), fmt('0));
    o = observe(1'b1);
    check(o == '0, "reset_mod6", fmt(o), fmt('0));
    rstn = 1'b1;

    for (int c = 0; c < 22; c++) begin
      @(posedge clk);
      #1;
      o = observe(1'b0);
      check(o == '0, $sformatf("idle_c%0d", c), fmt(o), fmt('0));
    end

    foreach (vecs[i]) apply(vecs[i], i);

    // Error on the same edge as err_clr: clear wins for sticky, count restarts at 1.
    if8.gray_in = 3'b001;
    repeat (3) @(posedge clk);
    #1;
    if8.err_clr = 1'b1;
    @(posedge clk);
    #1;
    if8.err_clr = 1'b0;
    o = observe(1'b0);
    check(o == obs_t'{3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1}, "clr_with_err", fmt(o),
          fmt(obs_t'{3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1}));
    @(posedge clk);
    #1;
    o = observe(1'b0);
    check(o == obs_t'{3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}, "clr_after", fmt(o),
          fmt(obs_t'{3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1}));

    // 260 back-to-back illegal jumps between 1 and 7: each pulses, count saturates.
    pulses = 0;
    for (int i = 0; i < 266; i++) begin
      if (i < 260) if8.gray_in = (i % 2 == 0) ? 3'b100 : 3'b001;
      @(posedge clk);
      #1;
      if (if8.err_pulse) pulses++;
    end
    check(pulses == 260, "sat_pulses", $sformatf("%0d", pulses), "260");
    o = observe(1'b0);
    check(o == obs_t'{3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd255}, "sat_count", fmt(o),
          fmt(obs_t'{3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd255}));

    // Reset while an error pulse is high, then release with no false error.
    if8.gray_in = 3'b110;
    repeat (4) @(posedge clk);
    #1;
    o = observe(1'b0);
    check(o.err && o.bin == 3'd4, "pre_reset_err", fmt(o), "bin=4 err=1");
    #2;
    rstn = 1'b0;
    #1;
    o = observe(1'b0);
    check(o == '0, "midstream_reset", fmt(o), fmt('0));
    if8.gray_in = 3'b000;
    if6.gray_in = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    rstn   = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (if8.err_pulse || if8.step_valid || if6.err_pulse || if6.step_valid) pulses++;
    end
    check(pulses == 0, "post_reset_quiet", $sformatf("%0d pulses", pulses), "0 pulses");
    o = observe(1'b0);
    check(o == '0, "post_reset_state", fmt(o), fmt('0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_count_decoder.md
Name: gray_count_decoder

Overview:
- Downstream consumer of the Gray-code up/down counters.
- Synchronises a Gray count bus into the local clock, decodes it to binary and classifies each observed change as one legal step up, one legal step down, or an error.
- Used where a Gray count produced elsewhere must be read safely as binary, with step, wrap and direction information for downstream control logic.

Parameters:
MOD_VALUE, 8, counter modulus; W = $clog2(MOD_VALUE) is the bus width.
SYNC_STAGES, 2, synchroniser depth on gray_in; legal range 2..4.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  single clock for the whole block.
rstn  input  1  asynchronous active-low reset; deasserts synchronously to clk outside this block.
gray_in  input  W  Gray count from the upstream counter; may be asynchronous to clk.
err_clr  input  1  synchronous clear of err_sticky and err_count.
bin_out  output  W  decoded binary count, registered.
step_valid  output  1  one-cycle pulse: a legal single step was decoded this cycle.
step_dn  output  1  direction of the step, valid with step_valid; 1 = down, 0 = up.
wrap_pulse  output  1  one-cycle pulse on a legal wrap (MOD_VALUE-1 -> 0 up, or 0 -> MOD_VALUE-1 down).
err_pulse  output  1  one-cycle pulse on an illegal change.
err_sticky  output  1  set by err_pulse; held until err_clr.
err_count  output  ERR_CNT_W  saturating count of err_pulse events.

Behaviour:
- Reset (async, rstn=0):
  - synchroniser flops = 0, reference register = 0, bin_out = 0;
  - all pulses = 0, err_sticky = 0, err_count = 0;
  - FSM = S_INIT.
- Synchroniser: SYNC_STAGES flops on gray_in, no logic between stages. Its output is g_s.
- Decode: b_s = gray2bin(g_s), where b[W-1] = g[W-1] and b[i] = b[i+1] ^ g[i].
- FSM:
  - S_INIT: the first cycle after reset release loads the reference (g_ref, b_ref) from g_s/b_s. bin_out = b_s. No pulses. Next state S_TRACK.
  - S_TRACK: each cycle compare g_s with g_ref.
    - g_s == g_ref: no pulses, outputs hold.
    - Legal up: b_s == b_ref+1 mod MOD_VALUE and (popcount(g_s^g_ref) == 1, or the transition is the wrap MOD_VALUE-1 -> 0). Result: step_valid=1, step_dn=0.
    - Legal down: b_s == b_ref-1 mod MOD_VALUE under the same distance rule, including the wrap 0 -> MOD_VALUE-1. Result: step_valid=1, step_dn=1.
    - wrap_pulse=1 together with step_valid on either wrap transition.
    - Anything else is illegal: multi-bit change that is not a wrap, b_s >= MOD_VALUE, or a jump of 2 or more. Result: err_pulse=1, err_sticky=1, err_count+1 (saturate at all-ones).
    - On any change, legal or illegal, reference <= g_s/b_s and bin_out <= b_s, so the block resynchronises to the new value.
- The non-power-of-two wrap (e.g. MOD 6: gray 111 -> 000) is a multi-bit change and is legal only as a wrap.
- Latency: a gray_in change stable before edge t appears on bin_out, together with its pulse, at edge t + SYNC_STAGES + 1.
- Pulses are registered outputs, high for exactly one cycle per detected change.
- Back-to-back changes on consecutive synchronised cycles each produce their own pulse.
- err_clr in the same cycle as an err_pulse:
  - the clear wins for err_sticky, which reads 0;
  - err_count loads 1, not 0;
  - err_pulse still fires.
- err_count saturated at all-ones: further errors hold the value; err_sticky and err_pulse still behave normally.
- Reset mid-operation: immediate return to reset values. After release the block goes back through S_INIT, so no false error is raised against a stale reference.
- Only synchronous gray_in sampling is allowed. The bus relies on Gray single-bit change; no handshake exists.

Decomposition:
- Package gray_pkg holds:
  - function gray2bin(W-generic via parameterised width);
  - function popcount1 (true if exactly one bit set);
  - FSM enum type state_t {S_INIT, S_TRACK}.
- Sub-module gray_bus_sync:
  - parameters WIDTH and STAGES; ports clk, rstn, d, q;
  - a flop chain reusable by other CDC points.
- Top level holds the FSM, the classification logic and the error counter.

Test Plan:
- Reset, then hold gray_in=000 (MOD 8) -> bin_out=0 and no pulses for 20 cycles after S_INIT.
- Drive a down counter (MOD 8) through gray 000,100,101,111,110,010,011,001,000 -> bin_out 0,7,6,...,0.
  - Expect step_valid with step_dn=1 for each step.
  - Expect wrap_pulse on 0->7 only.
  - Each update lands SYNC_STAGES+1 cycles after the input change.
- Up sequence 6->7->0 (gray 101,100,000) -> step_dn=0 on both steps; wrap_pulse on 7->0.
- Jump gray 000 -> 011 (0->2) -> err_pulse=1, err_sticky=1, err_count=1, bin_out=2.
  - A following 011 -> 010 (2->3) is then legal up.
- MOD_VALUE=6:
  - gray 111 -> 000 (5->0) -> legal wrap up.
  - Force gray 101 (binary 6) -> err_pulse, because the value is >= MOD_VALUE.
- Errors and reset:
  - 260 consecutive illegal changes with ERR_CNT_W=8 -> err_count holds at 255.
  - err_clr concurrent with an error -> err_sticky=0, err_count=1.
  - Assert rstn mid-stream -> all outputs 0 immediately; no err_pulse after release.
